mlp_datapath_core: RTL and testbench

//  Support datapath around the 2x2 systolic MMU. It contains three functions:
//  - a dual-column weight FIFO that feeds the MMU column inputs with systolic skew;
//  - a two-column accumulator that aligns and sums the MMU partial sums;
//  - two activation lanes (ReLU -> normalize -> quantize) that produce int8 for UB refill.
//  The MLP controller drives pop/valid/enable; lane outputs are packed by the parent.

---
 rtl/mlp_datapath_core.sv | 214 +++++++++++++++++++++
 tb/tb_mlp_datapath_core.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_datapath_core.sv
// MLP support datapath: skewed weight FIFO, column accumulator,
// and two ReLU/normalize/quantize activation lanes.
module mlp_datapath_core #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wf_clear,
  input  logic               wf_push_col0,
  input  logic               wf_push_col1,
  input  logic [7:0]         wf_data_in,
  input  logic               wf_pop,
  output logic [7:0]         wf_col0_out,
  output logic [7:0]         wf_col1_out,
  output logic [7:0]         wf_col1_raw,
  input  logic               acc_valid_in,
  input  logic               acc_enable,
  input  logic               acc_addr_sel,
  input  logic signed [15:0] mmu_col0_in,
  input  logic signed [15:0] mmu_col1_in,
  output logic signed [31:0] acc_col0_out,
  output logic signed [31:0] acc_col1_out,
  output logic               acc_valid_out,
  input  logic signed [15:0] norm_gain,
  input  logic signed [31:0] norm_bias,
  input  logic [4:0]         norm_shift,
  input  logic signed [15:0] q_inv_scale,
  input  logic signed [7:0]  q_zero_point,
  input  logic signed [31:0] target_in,
  output logic               ap_valid_out,
  output logic signed [7:0]  ap_col0_out,
  output logic signed [7:0]  ap_col1_out,
  output logic               loss_valid,
  output logic [31:0]        loss_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem0_q [FIFO_DEPTH];
  logic [7:0]    mem1_q [FIFO_DEPTH];
  logic [AW-1:0] rd0_q, wr0_q, rd1_q, wr1_q;
  logic [AW:0]   cnt0_q, cnt1_q;
  logic [7:0]    wf0_q, wf1_stage_q, wf1_q;
  logic          wf_rst;
  logic          empty0, empty1;
  logic          pop0_d, pop1_d, push0_d, push1_d;
  logic [7:0]    head0_d, head1_d;

  assign wf_rst  = reset | wf_clear;
  assign empty0  = (cnt0_q == '0);
  assign empty1  = (cnt1_q == '0);
  assign pop0_d  = wf_pop & ~empty0;
  assign pop1_d  = wf_pop & ~empty1;
  assign push0_d = wf_push_col0 & ((cnt0_q != FULL) | pop0_d);
  assign push1_d = wf_push_col1 & ((cnt1_q != FULL) | pop1_d);
  assign head0_d = empty0 ? 8'd0 : mem0_q[rd0_q];
  assign head1_d = empty1 ? 8'd0 : mem1_q[rd1_q];

  // Weight storage, written on accepted pushes
  always_ff @(posedge clk) begin
    if (!wf_rst && push0_d) mem0_q[wr0_q] <= wf_data_in;
    if (!wf_rst && push1_d) mem1_q[wr1_q] <= wf_data_in;
  end

  // Queue pointers and skewed column outputs
  always_ff @(posedge clk) begin
    if (wf_rst) begin
      rd0_q       <= '0;
      wr0_q       <= '0;
      rd1_q       <= '0;
      wr1_q       <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      wf0_q       <= '0;
      wf1_stage_q <= '0;
      wf1_q       <= '0;
    end else begin
      if (push0_d) wr0_q <= wr0_q + 1'b1;
      if (push1_d) wr1_q <= wr1_q + 1'b1;
      if (pop0_d)  rd0_q <= rd0_q + 1'b1;
      if (pop1_d)  rd1_q <= rd1_q + 1'b1;
      cnt0_q <= cnt0_q + (AW+1)'(push0_d) - (AW+1)'(pop0_d);
      cnt1_q <= cnt1_q + (AW+1)'(push1_d) - (AW+1)'(pop1_d);
      if (wf_pop) begin
        wf0_q       <= head0_d;
        wf1_stage_q <= head1_d;
      end
      wf1_q <= wf1_stage_q;
    end
  end

  assign wf_col0_out = wf0_q;
  assign wf_col1_out = wf1_q;
  assign wf_col1_raw = head1_d;

  logic signed [15:0] c0_dly_q;
  logic               v_dly_q;
  logic signed [31:0] bank0_q [2];
  logic signed [31:0] bank1_q [2];
  logic signed [31:0] acc0_q, acc1_q;
  logic               accv_q;
  logic signed [31:0] ext0_d, ext1_d, sum0_d, sum1_d;

  assign ext0_d = {{16{c0_dly_q[15]}}, c0_dly_q};
  assign ext1_d = {{16{mmu_col1_in[15]}}, mmu_col1_in};
  assign sum0_d = acc_enable ? bank0_q[acc_addr_sel] + ext0_d : ext0_d;
  assign sum1_d = acc_enable ? bank1_q[acc_addr_sel] + ext1_d : ext1_d;

  // Align col0 with the late col1 and update the selected bank
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_dly_q <= '0;
      v_dly_q  <= 1'b0;
      bank0_q  <= '{default: '0};
      bank1_q  <= '{default: '0};
      acc0_q   <= '0;
      acc1_q   <= '0;
      accv_q   <= 1'b0;
    end else begin
      c0_dly_q <= mmu_col0_in;
      v_dly_q  <= acc_valid_in;
      accv_q   <= v_dly_q;
      if (v_dly_q) begin
        bank0_q[acc_addr_sel] <= sum0_d;
        bank1_q[acc_addr_sel] <= sum1_d;
        acc0_q <= sum0_d;
        acc1_q <= sum1_d;
      end
    end
  end

  assign acc_col0_out  = acc0_q;
  assign acc_col1_out  = acc1_q;
  assign acc_valid_out = accv_q;

  logic signed [31:0] lane_in [2];
  logic signed [31:0] r_q [2];
  logic signed [31:0] n_q [2];
  logic signed [7:0]  q_q [2];
  logic               v1_q, v2_q, v3_q;
  logic [31:0]        loss_q;
  logic signed [31:0] r_d [2];
  logic signed [31:0] n_d [2];
  logic signed [7:0]  q_d [2];
  logic signed [47:0] np_d [2];
  logic signed [47:0] nsh_d [2];
  logic signed [48:0] ns_d [2];
  logic signed [47:0] qp_d [2];
  logic signed [47:0] qsh_d [2];
  logic signed [48:0] qa_d [2];
  logic signed [32:0] diff_d;
  logic [32:0]        mag_d;
  logic [31:0]        loss_d;

  assign lane_in[0] = acc0_q;
  assign lane_in[1] = acc1_q;

  // Per-lane ReLU, normalize and quantize arithmetic
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      r_d[i]   = lane_in[i][31] ? 32'sd0 : lane_in[i];
      np_d[i]  = 48'(r_q[i]) * 48'(norm_gain);
      nsh_d[i] = np_d[i] >>> norm_shift;
      ns_d[i]  = 49'(nsh_d[i]) + 49'(norm_bias);
      if (!ns_d[i][48] && (|ns_d[i][47:31]))
        n_d[i] = 32'sh7fff_ffff;
      else if (ns_d[i][48] && !(&ns_d[i][47:31]))
        n_d[i] = 32'sh8000_0000;
      else
        n_d[i] = ns_d[i][31:0];
      qp_d[i]  = 48'(n_q[i]) * 48'(q_inv_scale);
      qsh_d[i] = qp_d[i] >>> 8;
      qa_d[i]  = 49'(qsh_d[i]) + 49'(q_zero_point);
      if (!qa_d[i][48] && (|qa_d[i][47:7]))
        q_d[i] = 8'sd127;
      else if (qa_d[i][48] && !(&qa_d[i][47:7]))
        q_d[i] = -8'sd128;
      else
        q_d[i] = qa_d[i][7:0];
    end
    diff_d = 33'(n_q[0]) - 33'(target_in);
    mag_d  = diff_d[32] ? (~diff_d + 33'd1) : diff_d;
    loss_d = (|mag_d[32:31]) ? 32'h7fff_ffff : mag_d[31:0];
  end

  // Three-stage lane pipeline; stages advance every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '{default: '0};
      n_q    <= '{default: '0};
      q_q    <= '{default: '0};
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      loss_q <= '0;
    end else begin
      r_q    <= r_d;
      n_q    <= n_d;
      q_q    <= q_d;
      v1_q   <= accv_q;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      loss_q <= loss_d;
    end
  end

  assign ap_valid_out = v3_q;
  assign ap_col0_out  = q_q[0];
  assign ap_col1_out  = q_q[1];
  assign loss_valid   = v3_q;
  assign loss_out     = loss_q;

endmodule

// File: tb/tb_mlp_datapath_core.sv
// Scoreboard bench for mlp_datapath_core.
// Expected values come from a behavioural model kept in the bench.
module tb_mlp_datapath_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, wf_clear, wf_push_col0, wf_push_col1, wf_pop;
  logic [7:0]         wf_data_in, wf_col0_out, wf_col1_out, wf_col1_raw;
  logic               acc_valid_in, acc_enable, acc_addr_sel, acc_valid_out;
  logic signed [15:0] mmu_col0_in, mmu_col1_in, norm_gain, q_inv_scale;
  logic signed [31:0] acc_col0_out, acc_col1_out, norm_bias, target_in;
  logic [4:0]         norm_shift;
  logic signed [7:0]  q_zero_point, ap_col0_out, ap_col1_out;
  logic               ap_valid_out, loss_valid;
  logic [31:0]        loss_out;

  mlp_datapath_core #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wf_clear(wf_clear),
    .wf_push_col0(wf_push_col0), .wf_push_col1(wf_push_col1),
    .wf_data_in(wf_data_in), .wf_pop(wf_pop),
    .wf_col0_out(wf_col0_out), .wf_col1_out(wf_col1_out),
    .wf_col1_raw(wf_col1_raw),
    .acc_valid_in(acc_valid_in), .acc_enable(acc_enable),
    .acc_addr_sel(acc_addr_sel),
    .mmu_col0_in(mmu_col0_in), .mmu_col1_in(mmu_col1_in),
    .acc_col0_out(acc_col0_out), .acc_col1_out(acc_col1_out),
    .acc_valid_out(acc_valid_out),
    .norm_gain(norm_gain), .norm_bias(norm_bias), .norm_shift(norm_shift),
    .q_inv_scale(q_inv_scale), .q_zero_point(q_zero_point),
    .target_in(target_in),
    .ap_valid_out(ap_valid_out), .ap_col0_out(ap_col0_out),
    .ap_col1_out(ap_col1_out),
    .loss_valid(loss_valid), .loss_out(loss_out)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] e_a0[$], e_a1[$], e_loss[$];
  logic [7:0]  e_q0[$], e_q1[$];
  int          bank_m [2][2];

  localparam longint MAX32 = (64'sd1 <<< 31) - 1;
  localparam longint MIN32 = -(64'sd1 <<< 31);

  function automatic longint sat(longint v, longint lo, longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint f_norm(longint a, longint g, int sh, longint b);
    longint r, p;
    r = (a < 0) ? 0 : a;
    p = (r * g) >>> sh;
    return sat(p + b, MIN32, MAX32);
  endfunction

  function automatic longint f_quant(longint n, longint inv, longint zp);
    longint p;
    p = (n * inv) >>> 8;
    return sat(p + zp, -128, 127);
  endfunction

  function automatic longint f_loss(longint n, longint t);
    longint d;
    d = n - t;
    if (d < 0) d = -d;
    return (d > MAX32) ? MAX32 : d;
  endfunction

  typedef struct {
    int c0; int c1; bit en; bit sel;
    int gain; int shift; int bias; int inv; int zp; int tgt;
  } acc_case_t;

  task automatic model_push(input int c0, input int c1, input bit en,
                            input bit sel);
    int v0, v1;
    longint n0, n1;
    v0 = en ? bank_m[sel][0] + c0 : c0;
    v1 = en ? bank_m[sel][1] + c1 : c1;
    bank_m[sel][0] = v0;
    bank_m[sel][1] = v1;
    e_a0.push_back(v0);
    e_a1.push_back(v1);
    n0 = f_norm(v0, norm_gain, int'(norm_shift), norm_bias);
    n1 = f_norm(v1, norm_gain, int'(norm_shift), norm_bias);
    e_q0.push_back(8'(f_quant(n0, q_inv_scale, q_zero_point)));
    e_q1.push_back(8'(f_quant(n1, q_inv_scale, q_zero_point)));
    e_loss.push_back(32'(f_loss(n0, target_in)));
  endtask

  task automatic test_reset();
    reset = 1'b1; wf_clear = 0; wf_push_col0 = 0; wf_push_col1 = 0;
    wf_pop = 0; wf_data_in = 0; acc_valid_in = 0; acc_enable = 0;
    acc_addr_sel = 0; mmu_col0_in = 0; mmu_col1_in = 0;
    norm_gain = 256; norm_bias = 0; norm_shift = 8; q_inv_scale = 256;
    q_zero_point = 0; target_in = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wf_col0_out, wf_col1_out, wf_col1_raw} !== 24'd0) begin
      errors++;
      $display("FAIL reset_wf got=%h want=0",
               {wf_col0_out, wf_col1_out, wf_col1_raw});
    end
    checks++;
    if ({acc_col0_out, acc_col1_out, acc_valid_out} !== 65'd0) begin
      errors++;
      $display("FAIL reset_acc got=%h want=0",
               {acc_col0_out, acc_col1_out, acc_valid_out});
    end
    checks++;
    if ({ap_valid_out, ap_col0_out, ap_col1_out, loss_valid, loss_out}
        !== 50'd0) begin
      errors++;
      $display("FAIL reset_lane got=%h want=0",
               {ap_valid_out, ap_col0_out, ap_col1_out, loss_valid, loss_out});
    end
    reset = 1'b0;
    foreach (bank_m[i, j]) bank_m[i][j] = 0;
  endtask

  typedef struct { bit p0; bit p1; bit pop; bit clr; logic [7:0] d; } fstep_t;

  task automatic test_fifo();
    fstep_t tbl[$];
    logic [7:0] mq0[$], mq1[$];
    logic [7:0] m_c0, m_st, m_c1, m_raw;
    tbl = '{
      '{1,0,0,0,8'd11}, '{1,0,0,0,8'd22}, '{0,1,0,0,8'd33}, '{0,1,0,0,8'd44},
      '{0,0,1,0,8'd0},  '{0,0,1,0,8'd0},  '{0,0,0,0,8'd0},  '{0,0,0,0,8'd0},
      '{0,0,1,0,8'd0},  '{0,0,0,0,8'd0},  '{0,0,0,0,8'd0},
      '{1,0,0,0,8'd1},  '{1,0,0,0,8'd2},  '{1,0,0,0,8'd3},  '{1,0,0,0,8'd4},
      '{1,0,0,0,8'd5},
      '{0,0,1,0,8'd0},  '{0,0,1,0,8'd0},  '{0,0,1,0,8'd0},  '{0,0,1,0,8'd0},
      '{0,0,1,0,8'd0},  '{0,0,0,0,8'd0},
      '{1,1,0,0,8'd7},  '{0,1,0,0,8'd8},  '{0,0,0,1,8'd0},  '{0,0,1,0,8'd0},
      '{0,0,0,0,8'd0},  '{0,0,0,0,8'd0},
      '{1,0,0,0,8'd9},  '{1,0,1,0,8'd10}, '{0,0,1,0,8'd0},  '{0,0,1,0,8'd0},
      '{0,0,0,0,8'd0},  '{0,0,0,0,8'd0}
    };
    m_c0 = 0; m_st = 0; m_c1 = 0;
    foreach (tbl[k]) begin
      wf_push_col0 = tbl[k].p0;
      wf_push_col1 = tbl[k].p1;
      wf_pop       = tbl[k].pop;
      wf_clear     = tbl[k].clr;
      wf_data_in   = tbl[k].d;
      if (tbl[k].clr) begin
        mq0.delete(); mq1.delete();
        m_c0 = 0; m_st = 0; m_c1 = 0;
      end else begin
        m_c1 = m_st;
        if (tbl[k].pop) begin
          if (mq0.size() > 0) m_c0 = mq0.pop_front(); else m_c0 = 0;
          if (mq1.size() > 0) m_st = mq1.pop_front(); else m_st = 0;
        end
        if (tbl[k].p0 && mq0.size() < 4) mq0.push_back(tbl[k].d);
        if (tbl[k].p1 && mq1.size() < 4) mq1.push_back(tbl[k].d);
      end
      m_raw = (mq1.size() > 0) ? mq1[0] : 8'd0;
      @(negedge clk);
      checks++;
      if (wf_col0_out !== m_c0) begin
        errors++;
        $display("FAIL fifo_col0 step=%0d got=%0d want=%0d", k, wf_col0_out, m_c0);
      end
      checks++;
      if (wf_col1_out !== m_c1) begin
        errors++;
        $display("FAIL fifo_col1 step=%0d got=%0d want=%0d", k, wf_col1_out, m_c1);
      end
      checks++;
      if (wf_col1_raw !== m_raw) begin
        errors++;
        $display("FAIL fifo_raw step=%0d got=%0d want=%0d", k, wf_col1_raw, m_raw);
      end
    end
    wf_push_col0 = 0; wf_push_col1 = 0; wf_pop = 0; wf_clear = 0;
  endtask

  task automatic test_acc();
    acc_case_t tbl[$];
    tbl = '{
      '{100, -3, 0, 0, 256, 8, 0, 256, 0, 40},
      '{100, -3, 1, 0, 256, 8, 0, 256, 0, 40},
      '{100, -3, 1, 1, 256, 8, 0, 256, 0, 40},
      '{1000, -50, 0, 0, 256, 8, 0, 256, 0, 40},
      '{100, 7, 0, 0, 256, 8, 0, 256, 5, 40},
      '{100, -3, 0, 0, -3, 2, 1000, -10, -7, -20},
      '{32767, 32767, 0, 0, -32768, 0, 32'sh8000_0000, 256, 0, 2147483647}
    };
    foreach (tbl[c]) begin
      @(negedge clk);
      norm_gain    = 16'(tbl[c].gain);
      norm_shift   = 5'(tbl[c].shift);
      norm_bias    = tbl[c].bias;
      q_inv_scale  = 16'(tbl[c].inv);
      q_zero_point = 8'(tbl[c].zp);
      target_in    = tbl[c].tgt;
      acc_enable   = tbl[c].en;
      acc_addr_sel = tbl[c].sel;
      acc_valid_in = 1'b1;
      mmu_col0_in  = 16'(tbl[c].c0);
      model_push(tbl[c].c0, tbl[c].c1, tbl[c].en, tbl[c].sel);
      @(negedge clk);
      acc_valid_in = 1'b0;
      mmu_col0_in  = 0;
      mmu_col1_in  = 16'(tbl[c].c1);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k == 0) mmu_col1_in = 0;
        checks++;
        if (loss_valid !== ap_valid_out) begin
          errors++;
          $display("FAIL loss_valid case=%0d got=%b want=%b",
                   c, loss_valid, ap_valid_out);
        end
        if (acc_valid_out) begin
          checks++;
          if (e_a0.size() == 0) begin
            errors++;
            $display("FAIL acc_extra case=%0d got=1 want=0", c);
          end else begin
            logic [31:0] x0, x1;
            x0 = e_a0.pop_front();
            x1 = e_a1.pop_front();
            if (acc_col0_out !== x0 || acc_col1_out !== x1) begin
              errors++;
              $display("FAIL acc case=%0d got=%0d/%0d want=%0d/%0d", c,
                       acc_col0_out, acc_col1_out, $signed(x0), $signed(x1));
            end
          end
        end
        if (ap_valid_out) begin
          checks++;
          if (e_q0.size() == 0) begin
            errors++;
            $display("FAIL ap_extra case=%0d got=1 want=0", c);
          end else begin
            logic [7:0] y0, y1;
            logic [31:0] l0;
            y0 = e_q0.pop_front();
            y1 = e_q1.pop_front();
            l0 = e_loss.pop_front();
            if (ap_col0_out !== y0 || ap_col1_out !== y1) begin
              errors++;
              $display("FAIL ap case=%0d got=%0d/%0d want=%0d/%0d", c,
                       ap_col0_out, ap_col1_out, $signed(y0), $signed(y1));
            end
            checks++;
            if (loss_out !== l0) begin
              errors++;
              $display("FAIL loss case=%0d got=%0d want=%0d", c, loss_out, l0);
            end
          end
        end
      end
      checks++;
      if (e_a0.size() != 0 || e_q0.size() != 0) begin
        errors++;
        $display("FAIL acc_missing case=%0d got=%0d/%0d want=0/0",
                 c, e_a0.size(), e_q0.size());
        e_a0.delete(); e_a1.delete();
        e_q0.delete(); e_q1.delete(); e_loss.delete();
      end
    end
  endtask

  task automatic test_back_to_back();
    int a[4] = '{10, 20, 30, 40};
    int b[4] = '{-1, -2, -3, -4};
    int got = 0;
    norm_gain = 256; norm_shift = 8; norm_bias = 0;
    q_inv_scale = 256; q_zero_point = 0; target_in = 40;
    acc_enable = 1'b1; acc_addr_sel = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          acc_valid_in = (i < 4);
          mmu_col0_in  = (i < 4) ? 16'(a[i]) : 16'd0;
          mmu_col1_in  = (i > 0) ? 16'(b[i-1]) : 16'd0;
          if (i < 4) model_push(a[i], b[i], 1'b1, 1'b1);
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (acc_valid_out) begin
            checks++;
            if (e_a0.size() == 0) begin
              errors++;
              $display("FAIL b2b_acc_extra cyc=%0d got=1 want=0", k);
            end else begin
              logic [31:0] x0, x1;
              x0 = e_a0.pop_front();
              x1 = e_a1.pop_front();
              if (acc_col0_out !== x0 || acc_col1_out !== x1) begin
                errors++;
                $display("FAIL b2b_acc cyc=%0d got=%0d/%0d want=%0d/%0d", k,
                         acc_col0_out, acc_col1_out, $signed(x0), $signed(x1));
              end
            end
          end
          if (ap_valid_out) begin
            checks++;
            got++;
            if (e_q0.size() == 0) begin
              errors++;
              $display("FAIL b2b_ap_extra cyc=%0d got=1 want=0", k);
            end else begin
              logic [7:0] y0, y1;
              logic [31:0] l0;
              y0 = e_q0.pop_front();
              y1 = e_q1.pop_front();
              l0 = e_loss.pop_front();
              if (ap_col0_out !== y0 || ap_col1_out !== y1 || loss_out !== l0) begin
                errors++;
                $display("FAIL b2b_ap cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                         k, ap_col0_out, ap_col1_out, loss_out,
                         $signed(y0), $signed(y1), l0);
              end
            end
          end
        end
      end
    join
    acc_valid_in = 0; mmu_col0_in = 0; mmu_col1_in = 0; acc_enable = 0;
    checks++;
    if (got != 4 || e_a0.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=4", got);
      e_a0.delete(); e_a1.delete();
      e_q0.delete(); e_q1.delete(); e_loss.delete();
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    acc_valid_in = 1'b1; acc_enable = 1'b0; acc_addr_sel = 1'b0;
    mmu_col0_in = 100;
    @(negedge clk);
    acc_valid_in = 1'b0; mmu_col0_in = 0; mmu_col1_in = -3;
    @(negedge clk);
    mmu_col1_in = 0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({acc_valid_out, ap_valid_out, loss_valid} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_valid got=%b want=000",
               {acc_valid_out, ap_valid_out, loss_valid});
    end
    checks++;
    if (acc_col0_out !== 32'd0 || ap_col0_out !== 8'd0) begin
      errors++;
      $display("FAIL midreset_data got=%0d/%0d want=0/0",
               acc_col0_out, ap_col0_out);
    end
    reset = 1'b0;
    foreach (bank_m[i, j]) bank_m[i][j] = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (acc_valid_out || ap_valid_out) begin
        errors++;
        $display("FAIL midreset_drop cyc=%0d got=%b want=00",
                 k, {acc_valid_out, ap_valid_out});
      end
    end
    @(negedge clk);
    acc_valid_in = 1'b1; acc_enable = 1'b1; mmu_col0_in = 100;
    @(negedge clk);
    acc_valid_in = 1'b0; mmu_col0_in = 0; mmu_col1_in = -3;
    @(negedge clk);
    mmu_col1_in = 0; acc_enable = 1'b0;
    checks++;
    if (acc_valid_out !== 1'b1 || acc_col0_out !== 32'sd100 ||
        acc_col1_out !== -32'sd3) begin
      errors++;
      $display("FAIL midreset_bank got=%b/%0d/%0d want=1/100/-3",
               acc_valid_out, acc_col0_out, acc_col1_out);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fifo();
    test_acc();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
